// File: rtl/fb_swap_ctrl_pkg.sv
// Shared definitions for the frame-buffer swap controller: buffer index width,
// controller states and the err_sticky bit positions.
package fb_pkg;

    localparam int BUF_W = 2;

    localparam int ERR_DROP_BIT = 0;
    localparam int ERR_DONE_BIT = 1;

    typedef enum logic [0:0] {
        DRAW      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_e;

    localparam logic [0:0] ST_DRAW      = DRAW;
    localparam logic [0:0] ST_WAIT_SWAP = WAIT_SWAP;

endpackage

// File: rtl/fb_swap_ctrl_buf_alloc.sv
// Free-buffer picker: returns the lowest buffer index not currently used as
// front, back or (when valid) pending.
module fb_buf_alloc
    import fb_pkg::*;
#(
    parameter int NUM_BUF = 2
) (
    input  logic [BUF_W-1:0] front_idx,
    input  logic [BUF_W-1:0] back_idx,
    input  logic [BUF_W-1:0] pend_idx,
    input  logic             pend_valid,
    output logic [BUF_W-1:0] free_idx
);

    // Scan from the top down so the lowest unused index is the last one kept.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if ((BUF_W'(i) != front_idx) && (BUF_W'(i) != back_idx) &&
                !(pend_valid && (BUF_W'(i) == pend_idx))) begin
                free_idx = BUF_W'(i);
            end
        end
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Frame-buffer swap controller for double or triple buffering. Registers CPU
// pixel writes into the back buffer and rotates front/back/pending buffer
// indices on frame-complete and vblank events.
//
// state     | meaning
// ----------+------------------------------------------------------------
// DRAW      | CPU may draw into back_idx (cpu_ready=1)
// WAIT_SWAP | double buffer only: frame queued, waiting for vblank swap
module fb_swap_ctrl
    import fb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int FB_ADDR_W = 17,
    parameter int NUM_BUF   = 2,
    parameter int FB_WORDS  = 76800
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic                       cpu_we,
    input  logic [31:0]                cpu_waddr,
    input  logic [DATA_W-1:0]          cpu_din,
    input  logic                       cpu_done,
    input  logic                       disp_swap,
    output logic                       mem_we,
    output logic [BUF_W+FB_ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0]          mem_din,
    output logic [BUF_W-1:0]           front_sel,
    output logic                       cpu_ready,
    output logic [15:0]                frame_count,
    output logic [1:0]                 err_sticky
);

    logic [BUF_W-1:0] front_q, back_q, pend_q;
    logic             pend_valid_q;
    logic [0:0]       state_q;

    // Intermediate state after the swap has been applied, before done.
    logic [BUF_W-1:0] front_s, back_s, pend_s;
    logic             pend_valid_s;
    logic [0:0]       state_s;

    logic [BUF_W-1:0] front_n, back_n, pend_n;
    logic             pend_valid_n;
    logic [0:0]       state_n;
    logic [15:0]      frame_count_n;
    logic             done_ignored;
    logic             wr_ok;
    logic [BUF_W-1:0] free_idx;

    assign cpu_ready = (state_q == ST_DRAW);
    assign front_sel = front_q;
    assign wr_ok     = cpu_we && cpu_ready && (cpu_waddr < 32'(FB_WORDS));

    fb_buf_alloc #(
        .NUM_BUF (NUM_BUF)
    ) u_buf_alloc (
        .front_idx  (front_s),
        .back_idx   (back_s),
        .pend_idx   (pend_s),
        .pend_valid (pend_valid_s),
        .free_idx   (free_idx)
    );

    // Vblank swap on the pre-cycle state; promotes the pending frame to front.
    always_comb begin
        front_s       = front_q;
        back_s        = back_q;
        pend_s        = pend_q;
        pend_valid_s  = pend_valid_q;
        state_s       = state_q;
        frame_count_n = frame_count;
        if (disp_swap && pend_valid_q) begin
            front_s       = pend_q;
            pend_valid_s  = 1'b0;
            frame_count_n = frame_count + 16'd1;
            if (NUM_BUF == 2) begin
                back_s  = front_q;
                state_s = ST_DRAW;
            end
        end
    end

    // Frame-complete applied on top of the swap result; newest frame wins.
    always_comb begin
        front_n      = front_s;
        back_n       = back_s;
        pend_n       = pend_s;
        pend_valid_n = pend_valid_s;
        state_n      = state_s;
        done_ignored = 1'b0;
        if (cpu_done) begin
            if (state_s == ST_DRAW) begin
                pend_n       = back_s;
                pend_valid_n = 1'b1;
                if (NUM_BUF == 2) begin
                    state_n = ST_WAIT_SWAP;
                end else begin
                    back_n = pend_valid_s ? pend_s : free_idx;
                end
            end else begin
                done_ignored = 1'b1;
            end
        end
    end

    // Buffer bookkeeping, counters and sticky error flags.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            front_q      <= '0;
            back_q       <= BUF_W'(1);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            state_q      <= ST_DRAW;
            frame_count  <= '0;
            err_sticky   <= '0;
        end else begin
            front_q      <= front_n;
            back_q       <= back_n;
            pend_q       <= pend_n;
            pend_valid_q <= pend_valid_n;
            state_q      <= state_n;
            frame_count  <= frame_count_n;
            if (cpu_we && !wr_ok) err_sticky[ERR_DROP_BIT] <= 1'b1;
            if (done_ignored)     err_sticky[ERR_DONE_BIT] <= 1'b1;
        end
    end

    // One-cycle write register; back_q is the buffer of the frame being drawn now.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_din   <= '0;
        end else begin
            mem_we <= wr_ok;
            if (wr_ok) begin
                mem_waddr <= {back_q, cpu_waddr[FB_ADDR_W-1:0]};
                mem_din   <= cpu_din;
            end
        end
    end

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: a double-buffer and a triple-buffer instance share
// the same stimulus; each is compared every cycle with a reference model.
module tb_fb_swap_ctrl;

    localparam int AW2 = 17;
    localparam int FW2 = 76800;
    localparam int AW3 = 7;
    localparam int FW3 = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_waddr = '0;
    logic [31:0] cpu_din = '0;
    logic        cpu_done = 1'b0;
    logic        disp_swap = 1'b0;

    logic           d2_we, d3_we;
    logic [AW2+1:0] d2_addr;
    logic [AW3+1:0] d3_addr;
    logic [31:0]    d2_din, d3_din;
    logic [1:0]     d2_front, d3_front;
    logic           d2_ready, d3_ready;
    logic [15:0]    d2_fc, d3_fc;
    logic [1:0]     d2_err, d3_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          front;
        int          back;
        int          pend;
        bit          pv;
        int          fc;
        bit [1:0]    err;
        bit          we;
        longint      addr;
        logic [31:0] din;
    } mdl_t;

    mdl_t m2, m3;

    always #5 clk = ~clk;

    fb_swap_ctrl #(.DATA_W(32), .FB_ADDR_W(AW2), .NUM_BUF(2), .FB_WORDS(FW2)) dut2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .cpu_we(cpu_we), .cpu_waddr(cpu_waddr),
        .cpu_din(cpu_din), .cpu_done(cpu_done), .disp_swap(disp_swap),
        .mem_we(d2_we), .mem_waddr(d2_addr), .mem_din(d2_din), .front_sel(d2_front),
        .cpu_ready(d2_ready), .frame_count(d2_fc), .err_sticky(d2_err));

    fb_swap_ctrl #(.DATA_W(32), .FB_ADDR_W(AW3), .NUM_BUF(3), .FB_WORDS(FW3)) dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n), .cpu_we(cpu_we), .cpu_waddr(cpu_waddr),
        .cpu_din(cpu_din), .cpu_done(cpu_done), .disp_swap(disp_swap),
        .mem_we(d3_we), .mem_waddr(d3_addr), .mem_din(d3_din), .front_sel(d3_front),
        .cpu_ready(d3_ready), .frame_count(d3_fc), .err_sticky(d3_err));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: buffers as plain integers; triple-buffer free slot is 3-front-back.
    function automatic mdl_t upd(mdl_t m, int nb, int fbw, int aw, bit rn, bit we,
                                 logic [31:0] wa, logic [31:0] din, bit done, bit swap);
        mdl_t n;
        longint unsigned waddr;
        bit ready, ok;
        int newback;
        n = m;
        waddr = wa;
        if (!rn) begin
            n.front = 0; n.back = 1; n.pend = 0; n.pv = 0; n.fc = 0; n.err = 0;
            n.we = 0; n.addr = 0; n.din = 0;
            return n;
        end
        ready = (nb == 3) || !m.pv;
        ok = we && ready && (waddr < longint'(fbw));
        n.we = ok;
        if (ok) begin
            n.addr = (longint'(m.back) << aw) + longint'(waddr);
            n.din = din;
        end
        if (we && !ok) n.err[0] = 1'b1;
        if (swap && m.pv) begin
            n.fc = (m.fc + 1) % 65536;
            n.front = m.pend;
            n.pv = 0;
            if (nb == 2) n.back = m.front;
        end
        if (done) begin
            if (nb == 2 && n.pv) begin
                n.err[1] = 1'b1;
            end else begin
                newback = n.pv ? n.pend : (3 - n.front - n.back);
                n.pend = n.back;
                n.pv = 1;
                if (nb == 3) n.back = newback;
            end
        end
        return n;
    endfunction

    task automatic compare_all();
        check("d2_we", 64'(d2_we), 64'(m2.we));
        check("d2_front", 64'(d2_front), 64'(m2.front));
        check("d2_ready", 64'(d2_ready), 64'(!m2.pv));
        check("d2_fc", 64'(d2_fc), 64'(m2.fc));
        check("d2_err", 64'(d2_err), 64'(m2.err));
        if (m2.we) begin
            check("d2_addr", 64'(d2_addr), 64'(m2.addr));
            check("d2_din", 64'(d2_din), 64'(m2.din));
        end
        check("d3_we", 64'(d3_we), 64'(m3.we));
        check("d3_front", 64'(d3_front), 64'(m3.front));
        check("d3_ready", 64'(d3_ready), 64'd1);
        check("d3_fc", 64'(d3_fc), 64'(m3.fc));
        check("d3_err", 64'(d3_err), 64'(m3.err));
        if (m3.we) begin
            check("d3_addr", 64'(d3_addr), 64'(m3.addr));
            check("d3_din", 64'(d3_din), 64'(m3.din));
        end
    endtask

    task automatic step();
        @(posedge clk);
        m2 = upd(m2, 2, FW2, AW2, rst_n, cpu_we, cpu_waddr, cpu_din, cpu_done, disp_swap);
        m3 = upd(m3, 3, FW3, AW3, rst_n, cpu_we, cpu_waddr, cpu_din, cpu_done, disp_swap);
        #1;
        compare_all();
        cpu_we = 0; cpu_done = 0; disp_swap = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cpu_we = 1; cpu_waddr = 32'(a); cpu_din = d;
    endtask

    initial begin
        int r;
        m2 = upd(m2, 2, FW2, AW2, 1'b0, 0, 0, 0, 0, 0);
        m3 = m2;

        do_reset();
        check("rst_d2_front", 64'(d2_front), 64'd0);
        check("rst_d2_ready", 64'(d2_ready), 64'd1);
        check("rst_d2_err", 64'(d2_err), 64'd0);

        // Basic write into back buffer 1
        wr(5, 32'hAABBCCDD); step();
        check("w5_we", 64'(d2_we), 64'd1);
        check("w5_addr", 64'(d2_addr), (64'd1 << AW2) | 64'd5);
        check("w5_din", 64'(d2_din), 64'hAABBCCDD);

        // Done, dropped write, then swap
        cpu_done = 1; step();
        wr(3, 32'h1234); step();
        check("drop_we", 64'(d2_we), 64'd0);
        check("drop_err", 64'(d2_err), 64'd1);
        check("drop_ready", 64'(d2_ready), 64'd0);
        disp_swap = 1; step();
        check("swap_front", 64'(d2_front), 64'd1);
        check("swap_ready", 64'(d2_ready), 64'd1);
        check("swap_fc", 64'(d2_fc), 64'd1);
        wr(0, 32'h55); step();
        check("swap_back0", 64'(d2_addr), 64'd0);

        // Triple buffer done, done, swap
        do_reset();
        cpu_done = 1; step();
        wr(7, 32'h7); step();
        check("t_back2", 64'(d3_addr), (64'd2 << AW3) | 64'd7);
        cpu_done = 1; step();
        check("t_ready", 64'(d3_ready), 64'd1);
        wr(8, 32'h8); step();
        check("t_back1", 64'(d3_addr), (64'd1 << AW3) | 64'd8);
        disp_swap = 1; step();
        check("t_front", 64'(d3_front), 64'd2);
        check("t_fc", 64'(d3_fc), 64'd1);

        // Address range boundaries
        do_reset();
        wr(FW3 - 1, 32'h99); step();
        check("d3_last_we", 64'(d3_we), 64'd1);
        wr(FW3, 32'h9A); step();
        check("d3_oor_we", 64'(d3_we), 64'd0);
        check("d3_oor_err", 64'(d3_err), 64'd1);
        wr(FW2 - 1, 32'h77); step();
        check("d2_last_we", 64'(d2_we), 64'd1);
        wr(FW2, 32'h78); step();
        check("d2_oor_we", 64'(d2_we), 64'd0);
        check("d2_oor_err", 64'(d2_err), 64'd1);

        // Coincident swap and done from reset
        do_reset();
        disp_swap = 1; cpu_done = 1; step();
        check("co_front", 64'(d2_front), 64'd0);
        check("co_ready", 64'(d2_ready), 64'd0);
        disp_swap = 1; step();
        check("co_front2", 64'(d2_front), 64'd1);

        // Reset one cycle after done, with a write in flight
        do_reset();
        wr(9, 32'hDEAD); cpu_done = 1; step();
        rst_n = 0; wr(10, 32'hBEEF); step();
        rst_n = 1;
        check("mr_we", 64'(d2_we), 64'd0);
        check("mr_addr", 64'(d2_addr), 64'd0);
        check("mr_din", 64'(d2_din), 64'd0);
        check("mr_front", 64'(d2_front), 64'd0);
        check("mr_ready", 64'(d2_ready), 64'd1);
        check("mr_fc", 64'(d2_fc), 64'd0);
        check("mr_err", 64'(d2_err), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cpu_we = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 9);
            if (r < 6)      cpu_waddr = 32'($urandom_range(0, FW3 + 20));
            else if (r < 8) cpu_waddr = 32'($urandom_range(FW2 - 10, FW2 + 10));
            else            cpu_waddr = 32'($urandom_range(0, FW2 - 1));
            cpu_din = $urandom;
            cpu_done = ($urandom_range(0, 7) == 0);
            disp_swap = ($urandom_range(0, 7) == 0);
            step();
        end
        rst_n = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_swap_ctrl.md
FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 SHALL take parameter DATA_W, default 32, meaning pixel word width.
REQ-002 SHALL take parameter FB_ADDR_W, default 17, meaning word-address width of one frame buffer.
REQ-003 SHALL take parameter NUM_BUF, default 2, meaning buffer count; legal values are 2 (double) and 3 (triple).
REQ-004 SHALL take parameter FB_WORDS, default 76800, meaning valid words per buffer (at most 2**FB_ADDR_W).
REQ-005 SHALL have ports: clk_clk  in  1  sole clock; reset_reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: cpu_we  in  1  write strobe; cpu_waddr  in  32  pixel word address; cpu_din  in  DATA_W  pixel data; cpu_done  in  1  one-cycle frame-complete pulse.
REQ-007 SHALL have ports: disp_swap  in  1  one-cycle vblank pulse from the display side.
REQ-008 SHALL have ports: mem_we  out  1; mem_waddr  out  BUF_W+FB_ADDR_W  {buffer index, word address}; mem_din  out  DATA_W.
REQ-009 SHALL have ports: front_sel  out  BUF_W  buffer being scanned out; cpu_ready  out  1  back buffer writable; frame_count  out  16  frames presented; err_sticky  out  2  bit0 dropped write, bit1 ignored done. BUF_W = 2.

Function
REQ-010 SHALL hold state: front_idx, back_idx, pend_idx, pend_valid; all buffer indices are distinct whenever they are valid.
REQ-011 SHALL register writes with 1-cycle latency: when cpu_we && cpu_ready && cpu_waddr < FB_WORDS, the next cycle has mem_we=1, mem_waddr={back_idx, cpu_waddr[FB_ADDR_W-1:0]}, mem_din=cpu_din; otherwise mem_we=0.
REQ-012 SHALL drop cpu_we when cpu_ready=0 or cpu_waddr >= FB_WORDS, and set err_sticky[0].
REQ-013 SHALL use back_idx as sampled in the write cycle, so a write coincident with cpu_done lands in the completing frame.
REQ-014 SHALL run FSM states DRAW (cpu_ready=1) and WAIT_SWAP (cpu_ready=0); WAIT_SWAP is reachable only when NUM_BUF=2.
REQ-015 SHALL, on disp_swap with pend_valid=1: front_idx<=pend_idx, pend_valid<=0, frame_count+=1 (wrapping at 16 bits), and the old front becomes free.
REQ-016 SHALL, on disp_swap with pend_valid=0, leave all state unchanged, which repeats the front frame.
REQ-017 SHALL, for NUM_BUF=2, on cpu_done in DRAW: pend_idx<=back_idx, pend_valid<=1, go to WAIT_SWAP; a swap then sets back_idx<=old front and returns to DRAW.
REQ-018 SHALL, for NUM_BUF=3, on cpu_done: pend_idx<=back_idx, pend_valid<=1, back_idx<=free buffer (the old pend_idx if pend_valid was 1, so the newest frame wins); remains in DRAW.
REQ-019 SHALL ignore cpu_done in WAIT_SWAP and set err_sticky[1].
REQ-020 SHALL, when disp_swap and cpu_done coincide, apply the swap to pre-cycle state first and then apply done to the result; e.g. NUM_BUF=2, DRAW, pend_valid=0 results in no swap and a new pending frame.
REQ-021 SHALL present front_sel=front_idx, registered.

Reset
REQ-022 SHALL, while reset_reset_n=0 at a clk_clk edge, set front_idx=0, back_idx=1, pend_valid=0, pend_idx=0, state=DRAW, mem_we=0, mem_waddr=0, mem_din=0, cpu_ready=1, frame_count=0, err_sticky=0.
REQ-023 SHALL discard an in-flight write or pending frame on reset mid-operation; there is no asynchronous path.

Structure
REQ-024 SHALL place the state enum (DRAW, WAIT_SWAP), BUF_W and the err_sticky bit positions in shared package fb_pkg.
REQ-025 SHALL contain one sub-module, fb_buf_alloc, a combinational free-buffer picker (lowest index not front/back/pending); the write register and FSM are local.

Verification
REQ-026 Double buffer: write addr 5 data 0xAABBCCDD -> next cycle mem_we=1, mem_waddr={1,5}, mem_din=0xAABBCCDD.
REQ-027 Double buffer: cpu_done, then write addr 3 -> write dropped, err_sticky=01; disp_swap -> front_sel=1, back=0, cpu_ready=1, frame_count=1.
REQ-028 Triple buffer: done, done, swap -> after first done back=2; after second done pend=2, back=1; after swap front_sel=2, frame_count=1, cpu_ready stays 1 throughout.
REQ-029 Out-of-range write at cpu_waddr=FB_WORDS -> mem_we=0, err_sticky[0]=1.
REQ-030 Same-cycle disp_swap and cpu_done from reset (NUM_BUF=2) -> front_sel=0, pend_valid=1, state WAIT_SWAP; next swap -> front_sel=1.
REQ-031 Reset asserted one cycle after cpu_done -> all outputs at REQ-022 values on the following cycle.
